cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the stack CPU core.
- Drives instruction fetch, holds the instruction register, and runs memory load/store through a req/ack bus handshake.
- Converts the decoder's level control outputs (push, pop, load_fp, load_ip, wr_stk1, load, wr, byt) into single-cycle commit strobes for the stack, FP and IP registers.
- Sits between the decoder and the register/stack/memory-port datapath.

---
 rtl/cpu_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer (RST/FETCH/EXEC/MEM) for the stack CPU core.
// Latency: 2 cycles per ALU/jump instruction, 3 per load/store with zero-wait memory; outputs are combinational.
// Backpressure: mem_req holds until mem_ack; CPU_SEQ_TIMEOUT_EN adds a request timeout with sticky bus_err.
module cpu_sequencer #(
  parameter int TO_W   = 8,
  parameter int TO_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dec_load,
  input  logic       dec_wr,
  input  logic       dec_byt,
  input  logic       dec_push,
  input  logic       dec_pop,
  input  logic       dec_wr_stk1,
  input  logic       dec_load_fp,
  input  logic       dec_load_ip,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_byt,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       ip_inc,
  output logic       ip_we,
  output logic       fp_we,
  output logic       stk_push,
  output logic       stk_pop,
  output logic       stk1_we,
  output logic [1:0] state_o,
  output logic       bus_err
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_MEM   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   commit;
  logic   timeout;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_MAX - 1);

  logic [TO_W-1:0] to_cnt;
  logic            bus_err_q;

  // The TO_MAX-th consecutive unacknowledged request cycle abandons the request.
  assign timeout = mem_req && !mem_ack && (to_cnt == TO_LAST);
  assign bus_err = bus_err_q;

  // Wait counter restarts on every state entry (including a timeout retry); error is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (timeout || (state_d != state_q)) begin
        to_cnt <= '0;
      end else if (mem_req && !mem_ack) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (timeout) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  // State register; reset forces RST asynchronously so mem_req drops at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, bus controls and the single-cycle commit point of each instruction.
  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_byt  = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    commit   = 1'b0;
    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          state_d = S_EXEC;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (dec_load || dec_wr) begin
          state_d = S_MEM;
        end else begin
          commit  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        // A write wins over a simultaneous load request.
        mem_we   = dec_wr;
        mem_byt  = dec_byt;
        if (mem_ack) begin
          commit  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // Level decoder controls become strobes only in the commit cycle.
  always_comb begin
    stk_push = commit && dec_push;
    stk_pop  = commit && dec_pop;
    stk1_we  = commit && dec_wr_stk1;
    fp_we    = commit && dec_load_fp;
    ip_we    = commit && dec_load_ip;
    ip_inc   = commit && !dec_load_ip;
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed test of the cpu_sequencer control flow.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
// Expected output vectors are hand-derived per cycle.
module tb_cpu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       dec_load, dec_wr, dec_byt, dec_push, dec_pop;
  logic       dec_wr_stk1, dec_load_fp, dec_load_ip;
  logic       mem_ack;
  logic       mem_req, mem_we, mem_byt, addr_sel, ir_we, ip_inc, ip_we, fp_we;
  logic       stk_push, stk_pop, stk1_we, bus_err;
  logic [1:0] state_o;

  int checks   = 0;
  int failures = 0;

  cpu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dec_load    (dec_load),
    .dec_wr      (dec_wr),
    .dec_byt     (dec_byt),
    .dec_push    (dec_push),
    .dec_pop     (dec_pop),
    .dec_wr_stk1 (dec_wr_stk1),
    .dec_load_fp (dec_load_fp),
    .dec_load_ip (dec_load_ip),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_byt     (mem_byt),
    .addr_sel    (addr_sel),
    .ir_we       (ir_we),
    .ip_inc      (ip_inc),
    .ip_we       (ip_we),
    .fp_we       (fp_we),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk1_we     (stk1_we),
    .state_o     (state_o),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: req we byt asel ir inc ipwe fpwe push pop s1 state[1:0] err
  function automatic logic [13:0] mk(input logic req, input logic we, input logic byt,
                                     input logic asel, input logic ir, input logic inc,
                                     input logic ipwe, input logic fpwe, input logic push,
                                     input logic pop, input logic s1, input logic [1:0] st);
    return {req, we, byt, asel, ir, inc, ipwe, fpwe, push, pop, s1, st, 1'b0};
  endfunction

  function automatic logic [13:0] obs();
    return {mem_req, mem_we, mem_byt, addr_sel, ir_we, ip_inc, ip_we, fp_we,
            stk_push, stk_pop, stk1_we, state_o, bus_err};
  endfunction

  task automatic chk(input string tag, input logic [13:0] exp_v);
    logic [13:0] o;
    o = obs();
    checks++;
    assert (o === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic ld, input logic wr, input logic byt, input logic push,
                         input logic pop, input logic s1, input logic lfp, input logic lip);
    dec_load    = ld;
    dec_wr      = wr;
    dec_byt     = byt;
    dec_push    = push;
    dec_pop     = pop;
    dec_wr_stk1 = s1;
    dec_load_fp = lfp;
    dec_load_ip = lip;
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_ack = 1'b1;
    set_dec(0, 0, 0, 0, 1, 0, 0, 0);
    tick(); tick();
    #1 chk("in_reset", mk(0,0,0,0,0,0,0,0,0,0,0,2'd0));

    // Release: one RST cycle with everything low even though mem_ack is high.
    tick();
    rst_n = 1'b1;
    #1 chk("rst_cycle", mk(0,0,0,0,0,0,0,0,0,0,0,2'd0));
    tick();
    #1 chk("fetch0", mk(1,0,0,0,1,0,0,0,0,0,0,2'd1));

    // ALU pop, zero-wait: 2-cycle period.
    tick();
    #1 chk("alu_exec", mk(0,0,0,0,0,1,0,0,0,1,0,2'd2));
    tick();
    #1 chk("alu_fetch", mk(1,0,0,0,1,0,0,0,0,0,0,2'd1));
    tick();
    #1 chk("alu_exec2", mk(0,0,0,0,0,1,0,0,0,1,0,2'd2));

    // Jump with FP load alongside.
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 1, 1);
    #1 chk("jmp_fetch", mk(1,0,0,0,1,0,0,0,0,0,0,2'd1));
    tick();
    #1 chk("jmp_exec", mk(0,0,0,0,0,0,1,1,0,0,0,2'd2));

    // Store word with pop, ack delayed 3 cycles.
    tick();
    set_dec(0, 1, 0, 0, 1, 0, 0, 0);
    tick();
    mem_ack = 1'b0;
    #1 chk("st_exec", mk(0,0,0,0,0,0,0,0,0,0,0,2'd2));
    tick();
    #1 chk("st_wait1", mk(1,1,0,1,0,0,0,0,0,0,0,2'd3));
    tick();
    #1 chk("st_wait2", mk(1,1,0,1,0,0,0,0,0,0,0,2'd3));
    tick();
    #1 chk("st_wait3", mk(1,1,0,1,0,0,0,0,0,0,0,2'd3));
    tick();
    mem_ack = 1'b1;
    #1 chk("st_ack", mk(1,1,0,1,0,1,0,0,0,1,0,2'd3));
    tick();
    #1 chk("st_fetch", mk(1,0,0,0,1,0,0,0,0,0,0,2'd1));

    // Byte load with push, zero-wait.
    set_dec(1, 0, 1, 1, 0, 0, 0, 0);
    tick();
    #1 chk("ldb_exec", mk(0,0,0,0,0,0,0,0,0,0,0,2'd2));
    tick();
    #1 chk("ldb_mem", mk(1,0,1,1,0,1,0,0,1,0,0,2'd3));

    // Load+write together acts as a write with stk1 writeback; reset lands mid-MEM.
    tick();
    set_dec(1, 1, 0, 0, 0, 1, 0, 0);
    tick();
    mem_ack = 1'b0;
    #1 chk("lw_exec", mk(0,0,0,0,0,0,0,0,0,0,0,2'd2));
    tick();
    #1 chk("lw_mem", mk(1,1,0,1,0,0,0,0,0,0,0,2'd3));
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_mem", mk(0,0,0,0,0,0,0,0,0,0,0,2'd0));

    // Restart with a slow fetch: FETCH holds without ir_we.
    tick();
    rst_n = 1'b1;
    tick();
    #1 chk("refetch_wait", mk(1,0,0,0,0,0,0,0,0,0,0,2'd1));
    tick();
    #1 chk("refetch_hold", mk(1,0,0,0,0,0,0,0,0,0,0,2'd1));
    mem_ack = 1'b1;
    #1 chk("refetch_ack", mk(1,0,0,0,1,0,0,0,0,0,0,2'd1));
    set_dec(0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    #1 chk("replace_exec", mk(0,0,0,0,0,1,0,0,1,1,1,2'd2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
